// File: rtl/irq_priority_arbiter.sv
// Registered interrupt arbiter: latches requests into pending bits, masks them and offers the winner
// through a valid/ack handshake, tracking the in-service source until done. Optional: IRQ_RR_PRIO_EN.

module irq_pend_cell #(
   parameter bit IS_EDGE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic clr,
   output logic pend
);
   logic req_d;

   // A fresh edge coinciding with an ack clear must survive, so set dominates clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_d <= 1'b0;
         pend  <= 1'b0;
      end else begin
         req_d <= req;
         if (IS_EDGE) pend <= (req & ~req_d) | (pend & ~clr);
         else         pend <= req;
      end
   end
endmodule

module irq_priority_arbiter #(
   parameter int                 NUM_SRC   = 8,
   parameter int                 ID_W      = 3,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = 8'hFF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_SRC-1:0] src_req,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask_q,
   output logic [NUM_SRC-1:0] pending_q,
   output logic               irq_valid,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               irq_done,
   output logic               busy
);
   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_SERVICE} state_t;

   state_t             state;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] ack_clr;
   logic [31:0]        elig_pad;
   logic [5:0]         enc;
   logic [4:0]         win_id;
   logic               ack_fire;

   // Highest set index wins; pairwise reduction, five levels over a 32-wide padded vector.
   function automatic logic [5:0] tree_enc(input logic [31:0] v);
      logic [31:0]      vv;
      logic [31:0][4:0] ii;
      vv = v;
      for (int k = 0; k < 32; k++) ii[k] = 5'(k);
      for (int lv = 0; lv < 5; lv++) begin
         for (int k = 0; k < (16 >> lv); k++) begin
            ii[k] = vv[2*k+1] ? ii[2*k+1] : ii[2*k];
            vv[k] = vv[2*k+1] | vv[2*k];
         end
      end
      return {vv[0], ii[0]};
   endfunction

   assign ack_fire = (state == S_OFFER) & irq_ack;
   assign eligible = pending_q & mask_q;
   assign elig_pad = 32'(eligible);

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign ack_clr[i] = ack_fire & (irq_id == ID_W'(i));
      irq_pend_cell #(.IS_EDGE(EDGE_MASK[i])) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (src_req[i]),
         .clr   (ack_clr[i]),
         .pend  (pending_q[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       mask_q <= '0;
      else if (mask_we) mask_q <= mask_wdata;
   end

`ifdef IRQ_RR_PRIO_EN
   logic [ID_W-1:0]    ptr_q;
   logic [NUM_SRC-1:0] rot;
   int                 sum;

   // rot[NUM_SRC-1] maps to ptr-1, so the fixed encoder searches downward from the last grant.
   always_comb begin
      rot = '0;
      for (int j = 0; j < NUM_SRC; j++)
         for (int k = 0; k < NUM_SRC; k++)
            if (k == ((j + int'(ptr_q)) % NUM_SRC)) rot[j] = eligible[k];
   end

   assign enc = tree_enc(32'(rot));

   always_comb begin
      sum = int'(enc[4:0]) + int'(ptr_q);
      if (sum >= NUM_SRC) sum = sum - NUM_SRC;
      win_id = 5'(sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ptr_q <= '0;
      else if (ack_fire) ptr_q <= irq_id;
   end
`else
   assign enc    = tree_enc(elig_pad);
   assign win_id = enc[4:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         irq_valid <= 1'b0;
         irq_id    <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en & enc[5]) begin
                  state     <= S_OFFER;
                  irq_valid <= 1'b1;
                  irq_id    <= ID_W'(win_id);
               end
            end
            S_OFFER: begin
               // Ack beats withdraw; the offered id never changes while valid.
               if (irq_ack) begin
                  state     <= S_SERVICE;
                  irq_valid <= 1'b0;
                  busy      <= 1'b1;
               end else if (!en || !elig_pad[5'(irq_id)]) begin
                  state     <= S_IDLE;
                  irq_valid <= 1'b0;
               end
            end
            S_SERVICE: begin
               if (irq_done) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               irq_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
